// File: rtl/dla_reset_sequencer_pkg.sv
// Shared types and elaboration helpers for the staged reset sequencer.
//   seq_state_t : sequencer FSM states
//   cnt_width   : width of the hold/gap counter
//   idx_width   : width of the stage index
//   flat_idx    : position of (stage, copy) in the flattened o_sclrn bus
package dla_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_t;

  // Counter must hold the larger of the two cycle targets.
  function automatic int unsigned cnt_width(input int unsigned min_c,
                                            input int unsigned gap_c);
    int unsigned m;
    m = (min_c > gap_c) ? min_c : gap_c;
    return $clog2(m + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned flat_idx(input int unsigned k,
                                           input int unsigned c,
                                           input int unsigned ncopies);
    return k * ncopies + c;
  endfunction

endpackage

// File: rtl/dla_reset_pipe.sv
// One reset copy's output register chain.
//   clk      : clock
//   i_resetn : synchronous active-low clear of the whole chain
//   i_d      : stage release status
//   o_q      : i_d delayed by PIPE_DEPTH cycles (pass-through when 0)
module dla_reset_pipe #(
  parameter int PIPE_DEPTH = 1
) (
  input  logic clk,
  input  logic i_resetn,
  input  logic i_d,
  output logic o_q
);

  if (PIPE_DEPTH == 0) begin : g_bypass
    logic unused_pipe;
    assign unused_pipe = clk ^ i_resetn;
    assign o_q = i_d;
  end else begin : g_chain
    // Kept per copy so fan-out stays local to each consumer.
    (* dont_merge *) logic [PIPE_DEPTH-1:0] sr_q;

    // Clearing the chain keeps hardware-reset assertion at one cycle.
    always_ff @(posedge clk) begin
      if (!i_resetn) begin
        sr_q <= '0;
      end else begin
        sr_q[0] <= i_d;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
          sr_q[i] <= sr_q[i-1];
        end
      end
    end

    assign o_q = sr_q[PIPE_DEPTH-1];
  end

endmodule

// File: rtl/dla_reset_sequencer.sv
// Staged reset sequencer: holds all stages in reset for a minimum time after
// hardware reset or a software request, then releases them in ascending order.
//   clk              : clock
//   i_resetn         : synchronous active-low hardware reset
//   i_sw_reset_req   : software reset request, level sampled each cycle
//   o_sw_reset_ack   : one-cycle pulse after a software sequence completes
//   o_stage_released : per-stage release status (before output pipeline)
//   o_ready          : all stages released
//   o_sclrn          : active-low resets, bit k*NUM_COPIES+c
module dla_reset_sequencer
  import dla_reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES        = 3,
  parameter int NUM_COPIES        = 2,
  parameter int MIN_ASSERT_CYCLES = 16,
  parameter int STAGE_GAP_CYCLES  = 8,
  parameter int PIPE_DEPTH        = 1
) (
  input  logic                             clk,
  input  logic                             i_resetn,
  input  logic                             i_sw_reset_req,
  output logic                             o_sw_reset_ack,
  output logic [NUM_STAGES-1:0]            o_stage_released,
  output logic                             o_ready,
  output logic [NUM_STAGES*NUM_COPIES-1:0] o_sclrn
);

  if (NUM_STAGES < 1)        begin : g_bad_stages $fatal(1, "NUM_STAGES must be >= 1"); end
  if (NUM_COPIES < 1)        begin : g_bad_copies $fatal(1, "NUM_COPIES must be >= 1"); end
  if (MIN_ASSERT_CYCLES < 1) begin : g_bad_min    $fatal(1, "MIN_ASSERT_CYCLES must be >= 1"); end
  if (STAGE_GAP_CYCLES < 1)  begin : g_bad_gap    $fatal(1, "STAGE_GAP_CYCLES must be >= 1"); end
  if (PIPE_DEPTH < 0)        begin : g_bad_pipe   $fatal(1, "PIPE_DEPTH must be >= 0"); end

  localparam int unsigned CNT_W = cnt_width(MIN_ASSERT_CYCLES, STAGE_GAP_CYCLES);
  localparam int unsigned IDX_W = idx_width(NUM_STAGES);

  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_ASSERT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  seq_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] released_q, released_d;
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;
  logic                  pending_q, pending_d;

  // State register; hardware reset wins over everything.
  always_ff @(posedge clk) begin
    if (!i_resetn) begin
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      idx_q      <= '0;
      released_q <= '0;
      ready_q    <= 1'b0;
      ack_q      <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      released_q <= released_d;
      ready_q    <= ready_d;
      ack_q      <= ack_d;
      pending_q  <= pending_d;
    end
  end

  // Next-state logic. The cycle that releases the last stage also enters RUN,
  // so o_ready rises together with the final release bit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    released_d = released_q;
    ready_d    = ready_q;
    ack_d      = 1'b0;
    pending_d  = pending_q;

    if (i_sw_reset_req) begin
      state_d    = ST_HOLD;
      cnt_d      = '0;
      idx_d      = '0;
      released_d = '0;
      ready_d    = 1'b0;
      pending_d  = 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q >= CNT_MIN) begin
            cnt_d         = '0;
            idx_d         = '0;
            released_d[0] = 1'b1;
            if (NUM_STAGES == 1) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q >= CNT_GAP) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            for (int k = 0; k < NUM_STAGES; k++) begin
              if (IDX_W'(k) == idx_d) released_d[k] = 1'b1;
            end
            if (idx_d == LAST_IDX) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          ready_d = 1'b1;
          if (pending_q) begin
            ack_d     = 1'b1;
            pending_d = 1'b0;
          end
        end
        default: state_d = ST_HOLD;
      endcase
    end
  end

  assign o_stage_released = released_q;
  assign o_ready          = ready_q;
  assign o_sw_reset_ack   = ack_q;

  // Per-copy output chains.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    for (genvar c = 0; c < NUM_COPIES; c++) begin : g_copy
      dla_reset_pipe #(
        .PIPE_DEPTH(PIPE_DEPTH)
      ) u_pipe (
        .clk      (clk),
        .i_resetn (i_resetn),
        .i_d      (released_q[k]),
        .o_q      (o_sclrn[flat_idx(k, c, NUM_COPIES)])
      );
    end
  end

endmodule

// File: tb/tb_dla_reset_sequencer.sv
// Bench for dla_reset_sequencer: default, minimal and wide configurations
// share one stimulus stream; a timing model predicts every output per cycle.
module tb_dla_reset_sequencer;

  logic clk = 1'b0;
  logic resetn;
  logic req;

  logic       ack0, rdy0;
  logic [2:0] rel0;
  logic [5:0] s0;
  logic       ack1, rdy1;
  logic [0:0] rel1;
  logic [0:0] s1;
  logic       ack2, rdy2;
  logic [3:0] rel2;
  logic [11:0] s2;

  always #5 clk = ~clk;

  dla_reset_sequencer u_dut0 (
    .clk(clk), .i_resetn(resetn), .i_sw_reset_req(req),
    .o_sw_reset_ack(ack0), .o_stage_released(rel0), .o_ready(rdy0), .o_sclrn(s0)
  );

  dla_reset_sequencer #(
    .NUM_STAGES(1), .NUM_COPIES(1), .MIN_ASSERT_CYCLES(1),
    .STAGE_GAP_CYCLES(8), .PIPE_DEPTH(0)
  ) u_dut1 (
    .clk(clk), .i_resetn(resetn), .i_sw_reset_req(req),
    .o_sw_reset_ack(ack1), .o_stage_released(rel1), .o_ready(rdy1), .o_sclrn(s1)
  );

  dla_reset_sequencer #(
    .NUM_STAGES(4), .NUM_COPIES(3), .MIN_ASSERT_CYCLES(16),
    .STAGE_GAP_CYCLES(8), .PIPE_DEPTH(3)
  ) u_dut2 (
    .clk(clk), .i_resetn(resetn), .i_sw_reset_req(req),
    .o_sw_reset_ack(ack2), .o_stage_released(rel2), .o_ready(rdy2), .o_sclrn(s2)
  );

  typedef struct packed {
    logic [11:0] sclrn;
    logic [3:0]  rel;
    logic        ready;
    logic        ack;
  } obs_t;
  typedef obs_t [2:0] snap_t;

  snap_t exp_q [$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    n_ack0 = 0;
  int    n_ack2 = 0;

  // Model state: cycles since release start (-1 while held), with history
  // for the output pipeline, and a pending-ack flag per DUT.
  int t_hist [3][4];
  bit pend   [3];

  function automatic int p_min(input int d); return (d == 1) ? 1 : 16; endfunction
  function automatic int p_gap(input int d); return 8; endfunction
  function automatic int p_ns (input int d); return (d == 0) ? 3 : (d == 1) ? 1 : 4; endfunction
  function automatic int p_nc (input int d); return (d == 0) ? 2 : (d == 1) ? 1 : 3; endfunction
  function automatic int p_pd (input int d); return (d == 0) ? 1 : (d == 1) ? 0 : 3; endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Predict outputs after the coming edge from the inputs just driven.
  task automatic model_push();
    snap_t s;
    s = '0;
    for (int d = 0; d < 3; d++) begin
      obs_t o;
      int   last;
      o    = '0;
      last = p_min(d) + (p_ns(d) - 1) * p_gap(d);
      for (int j = 3; j > 0; j--) t_hist[d][j] = t_hist[d][j-1];
      if (!resetn) begin
        for (int j = 0; j < 4; j++) t_hist[d][j] = -1;
        pend[d] = 1'b0;
      end else if (req) begin
        t_hist[d][0] = -1;
        pend[d]      = 1'b1;
      end else begin
        if (t_hist[d][0] < 0)          t_hist[d][0] = 0;
        else if (t_hist[d][0] < 10000) t_hist[d][0] = t_hist[d][0] + 1;
        if (pend[d] && t_hist[d][0] == last + 1) begin
          o.ack   = 1'b1;
          pend[d] = 1'b0;
        end
      end
      for (int k = 0; k < p_ns(d); k++) begin
        o.rel[k] = (t_hist[d][0] >= p_min(d) + k * p_gap(d));
        for (int c = 0; c < p_nc(d); c++)
          o.sclrn[k * p_nc(d) + c] = (t_hist[d][p_pd(d)] >= p_min(d) + k * p_gap(d));
      end
      o.ready = (t_hist[d][0] >= last);
      s[d] = o;
    end
    exp_q.push_back(s);
  endtask

  task automatic run(input int n, input logic rn, input logic rq);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      resetn = rn;
      req    = rq;
      model_push();
    end
  endtask

  function automatic obs_t actual(input int d);
    obs_t o;
    o = '0;
    case (d)
      0: begin o.sclrn = 12'(s0); o.rel = 4'(rel0); o.ready = rdy0; o.ack = ack0; end
      1: begin o.sclrn = 12'(s1); o.rel = 4'(rel1); o.ready = rdy1; o.ack = ack1; end
      default: begin o.sclrn = s2; o.rel = rel2; o.ready = rdy2; o.ack = ack2; end
    endcase
    return o;
  endfunction

  // Compare each DUT against the oldest outstanding prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      snap_t e;
      e = exp_q.pop_front();
      if (ack0 === 1'b1) n_ack0++;
      if (ack2 === 1'b1) n_ack2++;
      for (int d = 0; d < 3; d++) begin
        obs_t a;
        a = actual(d);
        check($sformatf("d%0d sclrn t=%0t", d, $time), 32'(a.sclrn), 32'(e[d].sclrn));
        check($sformatf("d%0d released t=%0t", d, $time), 32'(a.rel), 32'(e[d].rel));
        check($sformatf("d%0d ready t=%0t", d, $time), 32'(a.ready), 32'(e[d].ready));
        check($sformatf("d%0d ack t=%0t", d, $time), 32'(a.ack), 32'(e[d].ack));
      end
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      for (int j = 0; j < 4; j++) t_hist[d][j] = -1;
      pend[d] = 1'b0;
    end
    resetn = 1'b0;
    req    = 1'b0;
    model_push();
    run(4, 1'b0, 1'b0);   // hardware reset held 5 edges
    run(50, 1'b1, 1'b0);  // full release, no ack
    run(3, 1'b1, 1'b1);   // software request from RUN
    run(50, 1'b1, 1'b0);
    run(1, 1'b1, 1'b1);   // software request ...
    run(27, 1'b1, 1'b0);  // ... then again with stages 0,1 released
    run(1, 1'b1, 1'b1);
    run(50, 1'b1, 1'b0);
    run(1, 1'b1, 1'b1);   // software request ...
    run(28, 1'b1, 1'b0);  // ... interrupted by hardware reset at idx=1
    run(1, 1'b0, 1'b0);
    run(50, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("d0 ack total", 32'(n_ack0), 32'd2);
    check("d2 ack total", 32'(n_ack2), 32'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dla_reset_sequencer.md
# dla_reset_sequencer

Parametrised reset sequencer for coreDLA. It generates NUM_STAGES ordered synchronous resets, each fanned out to NUM_COPIES duplicated outputs. Hardware reset and a software reset request both enforce a minimum assertion time on every stage, then release the stages in order with a fixed gap between them. It sits downstream of the top-level reset synchroniser and drives staged resets to the DMA, the PE array and the CSR/debug logic, so that consumers always come out of reset before their producers.

## Interface
- NUM_STAGES, 3: number of ordered reset stages; must be ≥1.
- NUM_COPIES, 2: copies per stage; each copy has its own register chain with dont_merge applied; must be ≥1.
- MIN_ASSERT_CYCLES, 16: minimum cycles all stages are held in reset after the reset source goes away; must be ≥1.
- STAGE_GAP_CYCLES, 8: cycles between the release of stage k and stage k+1; must be ≥1.
- PIPE_DEPTH, 1: extra output register stages per copy; must be ≥0.
- Illegal parameter values cause `$fatal` at elaboration.
- clk  input  1  sole clock.
- i_resetn  input  1  reset; synchronous, active-low, already synchronous to clk.
- i_sw_reset_req  input  1  software reset request, sampled every cycle.
- o_sw_reset_ack  output  1  one-cycle pulse when a software-requested sequence completes.
- o_stage_released  output  NUM_STAGES  per-stage release status, before the output pipeline.
- o_ready  output  1  high once all stages are released.
- o_sclrn  output  NUM_STAGES*NUM_COPIES  active-low synchronous resets; bit index is k*NUM_COPIES+c.

## Operation
- **Reset values.** While i_resetn=0, on the next edge every output goes to 0:
  - o_sclrn, o_stage_released, o_ready and o_sw_reset_ack are all 0.
  - The FSM is in HOLD with counter=0, stage index=0 and sw_pending=0.
  - The output pipeline registers are cleared too, so hardware-reset assertion latency is 1 cycle regardless of PIPE_DEPTH.
- **FSM states.** HOLD, RELEASE, RUN.
  - HOLD: all stages asserted. The counter increments each cycle. On reaching MIN_ASSERT_CYCLES, go to RELEASE with idx=0.
  - RELEASE: set released[idx] on entry, then clear the counter.
    - If idx=NUM_STAGES-1, go to RUN.
    - Otherwise count STAGE_GAP_CYCLES, then increment idx and release the next stage.
  - RUN: all stages released and o_ready=1. If sw_pending is set, pulse o_sw_reset_ack for one cycle and clear sw_pending.
- **Software request.**
  - If i_sw_reset_req=1 in any state: clear all released bits, clear o_ready, go to HOLD with counter=0, and set sw_pending.
  - A request held high keeps the FSM restarting in HOLD. The hold time counts from the first cycle after the request drops.
  - A request arriving during HOLD or RELEASE restarts the sequence; only one ack is issued.
- **Precedence.** i_resetn=0 overrides everything, including i_sw_reset_req. It also clears sw_pending, so no ack is issued for a request interrupted by hardware reset.
- **Widths.** Counter width is clog2(max(MIN_ASSERT_CYCLES, STAGE_GAP_CYCLES)+1). The stage index width is max(1, clog2(NUM_STAGES)). Counters saturate and never wrap.
- **Release order.** Release is strictly ascending by stage. Assertion always hits all stages at once.

## Timing
- Let E0 be the first edge at which i_resetn=1 is sampled.
- o_stage_released[k] rises MIN_ASSERT_CYCLES + k*STAGE_GAP_CYCLES cycles after E0.
- o_ready rises in the same cycle as o_stage_released[NUM_STAGES-1].
- o_sclrn[k*NUM_COPIES+c] follows o_stage_released[k] delayed by exactly PIPE_DEPTH cycles, identically for all copies.
- For a software request, let E0 be the first edge at which i_sw_reset_req=0 is sampled after the request. Release timing is then the same as above.
- Software-request assertion: o_stage_released drops 1 cycle after the request is sampled; o_sclrn drops 1+PIPE_DEPTH cycles after.
- o_sw_reset_ack pulses in the cycle after o_ready rises.
- NUM_STAGES=1: o_ready rises with stage 0; STAGE_GAP_CYCLES is unused.

## Structure
- Package dla_reset_sequencer_pkg holds:
  - the state enum typedef (HOLD/RELEASE/RUN);
  - the counter-width function;
  - the flattened-index helper function.
- Sub-module dla_reset_pipe: one copy's PIPE_DEPTH-deep register chain with synchronous clear and dont_merge. It passes the input through when PIPE_DEPTH=0. The sequencer instantiates it NUM_STAGES*NUM_COPIES times.

## Test plan
- **Hardware reset release.** Defaults (3 stages, MIN=16, GAP=8, PIPE=1); hold i_resetn low 5 cycles, then raise it.
  - o_stage_released bits rise at E0+16, E0+24 and E0+32; o_ready rises at E0+32.
  - o_sclrn rises 1 cycle after each stage, on bit pairs {1:0}, {3:2} and {5:4}.
  - o_sw_reset_ack never pulses.
- **Software request in RUN.** From RUN, pulse i_sw_reset_req for 3 cycles.
  - o_sclrn is all 0 within 2 cycles.
  - Release follows the same 16/24/32 offsets from the request's falling sample.
  - Exactly one ack pulse, at E0+33.
- **Software request mid-release.** Pulse i_sw_reset_req while stage 1 is released.
  - Stages 0 and 1 drop, the full sequence restarts from HOLD, and a single ack is issued at the end.
- **Hardware reset mid-sequence.** During a software sequence at idx=1, drop i_resetn for 1 cycle.
  - All outputs are 0 the next cycle.
  - The sequence restarts from HOLD and no ack is issued.
- **Minimal configuration.** NUM_STAGES=1, PIPE_DEPTH=0, MIN=1.
  - o_sclrn and o_ready rise 1 cycle after E0.
  - i_resetn low is reflected in o_sclrn after 1 cycle.
- **Wide configuration.** NUM_STAGES=4, NUM_COPIES=3, PIPE_DEPTH=3.
  - All 12 outputs within a stage toggle in the same cycle.
  - Stage k release is at MIN + k*GAP + 3 cycles.
